// File: rtl/cdecv_sequencer_if.sv
// ----------------------------------------------------------------------------
// cdecv_sequencer_if
//
// Purpose: groups the CDECv sequencer's datapath/monitor signals into one
// bundle. The sequencer takes the slave modport. The datapath and monitor
// side, or a testbench, takes the master modport.
//
// Signals (direction as seen by the sequencer / slave):
//   I          in   8        instruction register contents
//   SZCy       in   3        flags {S,Z,Cy}
//   run        in   1        1 = free-running, 0 = pause at instruction boundary
//   step       in   1        single-cycle pulse, one instruction while paused
//   xsrc       out  3        bus source select
//   xdst       out  10       one-hot load enables {FLG,R,T,I,WD,MA,C,B,A,PC}
//   aluop      out  4        ALU operation
//   we         out  1        memory write strobe
//   state      out  STATE_W  encoded current microstate
//   instr_done out  1        pulse in the final execute cycle of an instruction
//   paused     out  1        high in PAUSE
//   halted     out  1        high in HALT or TRAP
// ----------------------------------------------------------------------------
interface cdecv_sequencer_if #(
    parameter int unsigned STATE_W = 5
) ();

    logic [7:0]         I;
    logic [2:0]         SZCy;
    logic               run;
    logic               step;
    logic [2:0]         xsrc;
    logic [9:0]         xdst;
    logic [3:0]         aluop;
    logic               we;
    logic [STATE_W-1:0] state;
    logic               instr_done;
    logic               paused;
    logic               halted;

    modport slave (
        input  I, SZCy, run, step,
        output xsrc, xdst, aluop, we, state, instr_done, paused, halted
    );

    modport master (
        output I, SZCy, run, step,
        input  xsrc, xdst, aluop, we, state, instr_done, paused, halted
    );

endinterface

// File: rtl/cdecv_sequencer.sv
// ----------------------------------------------------------------------------
// cdecv_sequencer
//
// Purpose: registered control sequencer for the CDECv CPU. It holds the
// microstate register and decodes {state, I, SZCy} into the datapath control
// word (xsrc/xdst/aluop/we). It inserts MEM_WAIT idle cycles ahead of every
// microstate that consumes RD. It also handles monitor run/step control and
// traps illegal opcodes.
//
// Parameters:
//   MEM_WAIT  extra idle cycles before each RD-consuming microstate (0..7)
//   STATE_W   width of the encoded state output (>= 5)
//
// Ports:
//   clk       in   system clock, rising edge
//   n_reset   in   synchronous active-low reset
//   bus       slave modport of cdecv_sequencer_if (see that file for signals)
//
// Optional feature: define CDECV_SEQ_JCC_EN to enable the conditional jump
// class (opcode 0110). When it is undefined, 0110 traps.
//
// State encodings (fixed, distinct):
//   RST=0  F0=1   PAUSE=2 F1=3   F2=4   DEC=5   MOV0=6  ALU0=7  ALU1=8
//   ALU2=9 LD0=10 LD1=11  LD3=12 LD4=13 ST0=14  ST1=15  ST3=16  ST4=17
//   ST5=18 JMP0=19 JMP1=20 JMP3=21 HALT=22 TRAP=23
//
// Wait cycles are not separate states. An RD-consuming state is held, with
// an idle control word, until the wait counter reaches MEM_WAIT. The monitor
// therefore sees the target state during its wait cycles.
// ----------------------------------------------------------------------------
module cdecv_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned STATE_W  = 5
) (
    input  logic             clk,
    input  logic             n_reset,
    cdecv_sequencer_if.slave bus
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [4:0] S_RST   = 5'd0;
    localparam logic [4:0] S_F0    = 5'd1;
    localparam logic [4:0] S_PAUSE = 5'd2;
    localparam logic [4:0] S_F1    = 5'd3;
    localparam logic [4:0] S_F2    = 5'd4;
    localparam logic [4:0] S_DEC   = 5'd5;
    localparam logic [4:0] S_MOV0  = 5'd6;
    localparam logic [4:0] S_ALU0  = 5'd7;
    localparam logic [4:0] S_ALU1  = 5'd8;
    localparam logic [4:0] S_ALU2  = 5'd9;
    localparam logic [4:0] S_LD0   = 5'd10;
    localparam logic [4:0] S_LD1   = 5'd11;
    localparam logic [4:0] S_LD3   = 5'd12;
    localparam logic [4:0] S_LD4   = 5'd13;
    localparam logic [4:0] S_ST0   = 5'd14;
    localparam logic [4:0] S_ST1   = 5'd15;
    localparam logic [4:0] S_ST3   = 5'd16;
    localparam logic [4:0] S_ST4   = 5'd17;
    localparam logic [4:0] S_ST5   = 5'd18;
    localparam logic [4:0] S_JMP0  = 5'd19;
    localparam logic [4:0] S_JMP1  = 5'd20;
    localparam logic [4:0] S_JMP3  = 5'd21;
    localparam logic [4:0] S_HALT  = 5'd22;
    localparam logic [4:0] S_TRAP  = 5'd23;

    // Bus sources
    localparam logic [2:0] SRC_PC  = 3'd0;
    localparam logic [2:0] SRC_RD  = 3'd4;
    localparam logic [2:0] SRC_R   = 3'd5;
    localparam logic [2:0] SRC_FF  = 3'd7;

    // One-hot destinations
    localparam logic [9:0] DST_PC  = 10'h001;
    localparam logic [9:0] DST_MA  = 10'h010;
    localparam logic [9:0] DST_WD  = 10'h020;
    localparam logic [9:0] DST_I   = 10'h040;
    localparam logic [9:0] DST_T   = 10'h080;
    localparam logic [9:0] DST_R   = 10'h100;
    localparam logic [9:0] DST_FLG = 10'h200;

    // ALU operations
    localparam logic [3:0] OP_ZERO = 4'b0111;
    localparam logic [3:0] OP_INC  = 4'b1000;
    localparam logic [3:0] OP_ADD  = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;

    // Opcode classes on I[7:4]
    localparam logic [3:0] OPC_NOP  = 4'b0000;
    localparam logic [3:0] OPC_HALT = 4'b0001;
    localparam logic [3:0] OPC_ALU  = 4'b0011;
    localparam logic [3:0] OPC_MOV  = 4'b0100;
    localparam logic [3:0] OPC_JMP  = 4'b0101;
    localparam logic [3:0] OPC_JCC  = 4'b0110;
    localparam logic [3:0] OPC_LD   = 4'b1000;
    localparam logic [3:0] OPC_ST   = 4'b1100;

    localparam logic [2:0] WAIT_N = 3'(MEM_WAIT);

    // Register codes 01/10/11 map to A/B/C. The bus source code equals the
    // register code and the load enable is bit <code>. Code 00 never
    // reaches these helpers because DEC traps it.
    function automatic logic [2:0] f_reg_src(input logic [1:0] code);
        f_reg_src = {1'b0, code};
    endfunction

    function automatic logic [9:0] f_reg_dst(input logic [1:0] code);
        f_reg_dst = 10'h001 << code;
    endfunction

    function automatic logic [3:0] f_alu_op(input logic [1:0] sel);
        case (sel)
            2'b00:   f_alu_op = OP_ADD;
            2'b01:   f_alu_op = OP_SUB;
            2'b10:   f_alu_op = OP_AND;
            default: f_alu_op = OP_OR;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0] r_state;
    logic [2:0] r_wait;
    logic       r_step_ok;  // one-instruction permission granted in PAUSE
    logic       r_skip;     // Jcc not taken: finish after JMP1

    logic [4:0] w_next;
    logic       w_step_ok_d;
    logic       w_skip_d;
    logic       w_done;
    logic       w_rd_state;
    logic       w_stall;
    logic       w_go;
    logic [1:0] w_src_code;
    logic [1:0] w_dst_code;
    logic       w_jcc_cond;

    assign w_src_code = bus.I[3:2];
    assign w_dst_code = bus.I[1:0];
    assign w_go       = bus.run || r_step_ok;

    // Jcc condition on I[1:0]: Z=1, Z=0, Cy=1, S=1
`ifdef CDECV_SEQ_JCC_EN
    always_comb begin
        w_jcc_cond = 1'b0;
        case (bus.I[1:0])
            2'b00:   w_jcc_cond = bus.SZCy[1];
            2'b01:   w_jcc_cond = !bus.SZCy[1];
            2'b10:   w_jcc_cond = bus.SZCy[0];
            default: w_jcc_cond = bus.SZCy[2];
        endcase
    end
`else
    logic w_unused_flags;
    assign w_jcc_cond     = 1'b0;
    assign w_unused_flags = ^bus.SZCy;
`endif

    // Microstates that consume RD and so are preceded by wait cycles
    always_comb begin
        w_rd_state = 1'b0;
        case (r_state)
            S_F2, S_LD3, S_LD4, S_ST3, S_JMP3: w_rd_state = 1'b1;
            default:                          w_rd_state = 1'b0;
        endcase
    end

    assign w_stall = w_rd_state && (r_wait != WAIT_N);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_step_ok_d = r_step_ok;
        w_skip_d    = r_skip;
        w_done      = 1'b0;

        case (r_state)
            S_RST:   w_next = S_F0;
            S_F0:    w_next = w_go ? S_F1 : S_PAUSE;
            S_PAUSE: begin
                if (bus.run || bus.step) begin
                    w_next = S_F0;
                end
                if (bus.step) begin
                    w_step_ok_d = 1'b1;
                end
            end
            S_F1:    w_next = S_F2;
            S_F2:    w_next = w_stall ? S_F2 : S_DEC;
            S_DEC: begin
                w_skip_d = 1'b0;
                case (bus.I[7:4])
                    OPC_NOP:  w_done = 1'b1;
                    OPC_HALT: w_next = S_HALT;
                    OPC_MOV:  w_next = (w_src_code == 2'b00 || w_dst_code == 2'b00) ?
                                       S_TRAP : S_MOV0;
                    OPC_ALU:  w_next = (w_dst_code == 2'b00) ? S_TRAP : S_ALU0;
                    OPC_LD:   w_next = (w_dst_code == 2'b00) ? S_TRAP : S_LD0;
                    OPC_ST:   w_next = (w_src_code == 2'b00) ? S_TRAP : S_ST0;
                    OPC_JMP:  w_next = S_JMP0;
`ifdef CDECV_SEQ_JCC_EN
                    OPC_JCC: begin
                        w_next   = S_JMP0;
                        w_skip_d = !w_jcc_cond;
                    end
`endif
                    default:  w_next = S_TRAP;
                endcase
            end
            S_MOV0:  w_done = 1'b1;
            S_ALU0:  w_next = S_ALU1;
            S_ALU1:  w_next = S_ALU2;
            S_ALU2:  w_done = 1'b1;
            S_LD0:   w_next = S_LD1;
            S_LD1:   w_next = S_LD3;
            S_LD3:   w_next = w_stall ? S_LD3 : S_LD4;
            S_LD4:   w_done = !w_stall;
            S_ST0:   w_next = S_ST1;
            S_ST1:   w_next = S_ST3;
            S_ST3:   w_next = w_stall ? S_ST3 : S_ST4;
            S_ST4:   w_next = S_ST5;
            S_ST5:   w_done = 1'b1;
            S_JMP0:  w_next = S_JMP1;
            S_JMP1: begin
                // A not-taken Jcc has already stepped PC past the operand
                if (r_skip) begin
                    w_done = 1'b1;
                end else begin
                    w_next = S_JMP3;
                end
            end
            S_JMP3:  w_done = !w_stall;
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase

        // Instruction boundary: back to fetch and consume any granted step
        if (w_done) begin
            w_next      = S_F0;
            w_step_ok_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state   <= S_RST;
            r_wait    <= 3'd0;
            r_step_ok <= 1'b0;
            r_skip    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wait    <= w_stall ? r_wait + 3'd1 : 3'd0;
            r_step_ok <= w_step_ok_d;
            r_skip    <= w_skip_d;
        end
    end

    // ------------------------------------------------------------------
    // Control word decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.xsrc  = SRC_FF;
        bus.xdst  = '0;
        bus.aluop = OP_ZERO;
        bus.we    = 1'b0;

        case (r_state)
            S_F0: begin
                if (w_go) begin
                    bus.xsrc  = SRC_PC;
                    bus.xdst  = DST_MA | DST_R;
                    bus.aluop = OP_INC;
                end
            end
            S_LD0, S_ST0, S_JMP0: begin
                bus.xsrc  = SRC_PC;
                bus.xdst  = DST_MA | DST_R;
                bus.aluop = OP_INC;
            end
            S_F1, S_LD1, S_ST1, S_JMP1: begin
                bus.xsrc = SRC_R;
                bus.xdst = DST_PC;
            end
            S_F2: begin
                if (!w_stall) begin
                    bus.xsrc = SRC_RD;
                    bus.xdst = DST_I;
                end
            end
            S_MOV0: begin
                bus.xsrc = f_reg_src(w_src_code);
                bus.xdst = f_reg_dst(w_dst_code);
            end
            S_ALU0: begin
                bus.xsrc = f_reg_src(2'b01);
                bus.xdst = DST_T;
            end
            S_ALU1: begin
                bus.xsrc  = f_reg_src(2'b10);
                bus.xdst  = DST_R | DST_FLG;
                bus.aluop = f_alu_op(w_src_code);
            end
            S_ALU2: begin
                bus.xsrc = SRC_R;
                bus.xdst = f_reg_dst(w_dst_code);
            end
            S_LD3, S_ST3: begin
                if (!w_stall) begin
                    bus.xsrc = SRC_RD;
                    bus.xdst = DST_MA;
                end
            end
            S_LD4: begin
                if (!w_stall) begin
                    bus.xsrc = SRC_RD;
                    bus.xdst = f_reg_dst(w_dst_code);
                end
            end
            S_ST4: begin
                bus.xsrc = f_reg_src(w_src_code);
                bus.xdst = DST_WD;
            end
            S_ST5:   bus.we = 1'b1;
            S_JMP3: begin
                if (!w_stall) begin
                    bus.xsrc = SRC_RD;
                    bus.xdst = DST_PC;
                end
            end
            default: ;
        endcase
    end

    assign bus.state      = STATE_W'(r_state);
    assign bus.instr_done = w_done;
    assign bus.paused     = (r_state == S_PAUSE);
    assign bus.halted     = (r_state == S_HALT) || (r_state == S_TRAP);

endmodule

// File: tb/tb_cdecv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cdecv_sequencer
//
// Stimulus pushes the expected per-cycle control word onto a queue. A monitor
// on the falling edge pops one entry per cycle and compares it with the DUT
// outputs. Each stimulus segment starts one time unit after a rising edge and
// describes the cycle in progress plus the cycles that follow.
// ----------------------------------------------------------------------------
module tb_cdecv_sequencer;

    localparam int unsigned W  = 2;
    localparam int unsigned SW = 5;

    localparam logic [4:0] S_RST = 5'd0,  S_F0 = 5'd1,  S_PAUSE = 5'd2, S_F1 = 5'd3;
    localparam logic [4:0] S_F2 = 5'd4,   S_DEC = 5'd5, S_MOV0 = 5'd6,  S_ALU0 = 5'd7;
    localparam logic [4:0] S_ALU1 = 5'd8, S_ALU2 = 5'd9, S_LD0 = 5'd10, S_LD1 = 5'd11;
    localparam logic [4:0] S_LD3 = 5'd12, S_LD4 = 5'd13, S_ST0 = 5'd14, S_ST1 = 5'd15;
    localparam logic [4:0] S_ST3 = 5'd16, S_ST4 = 5'd17, S_ST5 = 5'd18, S_JMP0 = 5'd19;
    localparam logic [4:0] S_JMP1 = 5'd20, S_JMP3 = 5'd21, S_HALT = 5'd22, S_TRAP = 5'd23;

    localparam logic [3:0] OP_Z = 4'b0111, OP_INC = 4'b1000, OP_SUB = 4'b1011;
    localparam logic [3:0] OP_AND = 4'b0100;

    typedef struct {
        logic [4:0] st;
        logic [2:0] src;
        logic [9:0] dst;
        logic [3:0] op;
        logic       we;
        logic       done;
        logic       pau;
        logic       hlt;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic clk     = 1'b0;
    logic n_reset = 1'b0;

    cdecv_sequencer_if #(.STATE_W(SW)) bus ();

    cdecv_sequencer #(
        .MEM_WAIT (W),
        .STATE_W  (SW)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e = q.pop_front();
            n_cmp++;
            if ({bus.state, bus.xsrc, bus.xdst, bus.aluop, bus.we, bus.instr_done,
                 bus.paused, bus.halted} !==
                {m_e.st, m_e.src, m_e.dst, m_e.op, m_e.we, m_e.done, m_e.pau, m_e.hlt}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d src=%0d dst=%h op=%b we=%b done=%b pau=%b hlt=%b, want st=%0d src=%0d dst=%h op=%b we=%b done=%b pau=%b hlt=%b",
                         m_e.tag, bus.state, bus.xsrc, bus.xdst, bus.aluop, bus.we,
                         bus.instr_done, bus.paused, bus.halted, m_e.st, m_e.src, m_e.dst,
                         m_e.op, m_e.we, m_e.done, m_e.pau, m_e.hlt);
            end
        end
    end

    task automatic push(input logic [4:0] st, input logic [2:0] src, input logic [9:0] dst,
                        input logic [3:0] op, input logic we, input logic done,
                        input string tag);
        exp_t e;
        e.st   = st;
        e.src  = src;
        e.dst  = dst;
        e.op   = op;
        e.we   = we;
        e.done = done;
        e.pau  = (st == S_PAUSE);
        e.hlt  = (st == S_HALT) || (st == S_TRAP);
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] st, input string tag);
        push(st, 3'd7, 10'h000, OP_Z, 1'b0, 1'b0, tag);
    endtask

    task automatic waits(input logic [4:0] st, input string tag);
        repeat (W) idle(st, {tag, ".wait"});
    endtask

    // F0 (fetch) through F2, ending just before DEC
    task automatic fetch_seq(input string tag);
        push(S_F0, 3'd0, 10'h110, OP_INC, 1'b0, 1'b0, {tag, ".f0"});
        push(S_F1, 3'd5, 10'h001, OP_Z, 1'b0, 1'b0, {tag, ".f1"});
        waits(S_F2, {tag, ".f2"});
        push(S_F2, 3'd4, 10'h040, OP_Z, 1'b0, 1'b0, {tag, ".f2"});
    endtask

    // Operand fetch shared by LD/ST/JMP: x0 then x1
    task automatic opnd(input logic [4:0] s0, input logic [4:0] s1, input logic done1,
                        input string tag);
        push(s0, 3'd0, 10'h110, OP_INC, 1'b0, 1'b0, {tag, ".0"});
        push(s1, 3'd5, 10'h001, OP_Z, 1'b0, done1, {tag, ".1"});
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 1000) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
            q.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.I    = 8'h46;
        bus.SZCy = 3'b000;
        bus.run  = 1'b1;
        bus.step = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset release + MOV A,B
        idle(S_RST, "rst");
        n_reset = 1'b1;
        fetch_seq("mov");
        idle(S_DEC, "mov.dec");
        push(S_MOV0, 3'd1, 10'h004, OP_Z, 1'b0, 1'b1, "mov0");
        drain();

        // LD B
        bus.I = 8'h82;
        fetch_seq("ld");
        idle(S_DEC, "ld.dec");
        opnd(S_LD0, S_LD1, 1'b0, "ld");
        waits(S_LD3, "ld3");
        push(S_LD3, 3'd4, 10'h010, OP_Z, 1'b0, 1'b0, "ld3");
        waits(S_LD4, "ld4");
        push(S_LD4, 3'd4, 10'h004, OP_Z, 1'b0, 1'b1, "ld4");
        drain();

        // ST C
        bus.I = 8'hCC;
        fetch_seq("st");
        idle(S_DEC, "st.dec");
        opnd(S_ST0, S_ST1, 1'b0, "st");
        waits(S_ST3, "st3");
        push(S_ST3, 3'd4, 10'h010, OP_Z, 1'b0, 1'b0, "st3");
        push(S_ST4, 3'd3, 10'h020, OP_Z, 1'b0, 1'b0, "st4");
        push(S_ST5, 3'd7, 10'h000, OP_Z, 1'b1, 1'b1, "st5");
        drain();

        // ALU SUB -> A
        bus.I = 8'h35;
        fetch_seq("sub");
        idle(S_DEC, "sub.dec");
        push(S_ALU0, 3'd1, 10'h080, OP_Z, 1'b0, 1'b0, "sub.alu0");
        push(S_ALU1, 3'd2, 10'h300, OP_SUB, 1'b0, 1'b0, "sub.alu1");
        push(S_ALU2, 3'd5, 10'h002, OP_Z, 1'b0, 1'b1, "sub.alu2");
        drain();

        // ALU AND -> C
        bus.I = 8'h3B;
        fetch_seq("and");
        idle(S_DEC, "and.dec");
        push(S_ALU0, 3'd1, 10'h080, OP_Z, 1'b0, 1'b0, "and.alu0");
        push(S_ALU1, 3'd2, 10'h300, OP_AND, 1'b0, 1'b0, "and.alu1");
        push(S_ALU2, 3'd5, 10'h008, OP_Z, 1'b0, 1'b1, "and.alu2");
        drain();

        // NOP ends in DEC
        bus.I = 8'h00;
        fetch_seq("nop");
        push(S_DEC, 3'd7, 10'h000, OP_Z, 1'b0, 1'b1, "nop.dec");
        drain();

        // JMP
        bus.I = 8'h50;
        fetch_seq("jmp");
        idle(S_DEC, "jmp.dec");
        opnd(S_JMP0, S_JMP1, 1'b0, "jmp");
        waits(S_JMP3, "jmp3");
        push(S_JMP3, 3'd4, 10'h001, OP_Z, 1'b0, 1'b1, "jmp3");
        drain();

        // Reset in the middle of an F2 wait; wait counter must restart from zero
        bus.I = 8'h82;
        push(S_F0, 3'd0, 10'h110, OP_INC, 1'b0, 1'b0, "mrst.f0");
        push(S_F1, 3'd5, 10'h001, OP_Z, 1'b0, 1'b0, "mrst.f1");
        idle(S_F2, "mrst.w1");
        drain();
        n_reset = 1'b0;
        idle(S_F2, "mrst.w2");
        drain();
        n_reset = 1'b1;
        idle(S_RST, "mrst.rst");
        fetch_seq("mrst");
        idle(S_DEC, "mrst.dec");
        opnd(S_LD0, S_LD1, 1'b0, "mrst.ld");
        waits(S_LD3, "mrst.ld3");
        push(S_LD3, 3'd4, 10'h010, OP_Z, 1'b0, 1'b0, "mrst.ld3");
        waits(S_LD4, "mrst.ld4");
        push(S_LD4, 3'd4, 10'h004, OP_Z, 1'b0, 1'b1, "mrst.ld4");
        drain();

        // Pause, then one step gives exactly one instruction
        bus.I   = 8'h46;
        bus.run = 1'b0;
        idle(S_F0, "pause.f0");
        repeat (4) idle(S_PAUSE, "pause");
        drain();
        bus.step = 1'b1;
        idle(S_PAUSE, "step.pause");
        drain();
        bus.step = 1'b0;
        push(S_F0, 3'd0, 10'h110, OP_INC, 1'b0, 1'b0, "step.f0");
        drain();
        bus.step = 1'b1;  // mid-instruction step must be ignored
        push(S_F1, 3'd5, 10'h001, OP_Z, 1'b0, 1'b0, "step.f1");
        drain();
        bus.step = 1'b0;
        waits(S_F2, "step.f2");
        push(S_F2, 3'd4, 10'h040, OP_Z, 1'b0, 1'b0, "step.f2");
        idle(S_DEC, "step.dec");
        push(S_MOV0, 3'd1, 10'h004, OP_Z, 1'b0, 1'b1, "step.mov0");
        idle(S_F0, "step.f0b");
        repeat (3) idle(S_PAUSE, "step.repause");
        drain();

        // Resume and HALT
        bus.run = 1'b1;
        bus.I   = 8'h10;
        idle(S_PAUSE, "resume");
        fetch_seq("halt");
        idle(S_DEC, "halt.dec");
        repeat (2) idle(S_HALT, "halt");
        drain();
        bus.step = 1'b1;
        bus.run  = 1'b0;
        idle(S_HALT, "halt.step");
        drain();
        bus.step = 1'b0;
        bus.run  = 1'b1;
        repeat (2) idle(S_HALT, "halt.hold");
        drain();

        // One-cycle reset out of HALT, then illegal opcode 0xF0
        n_reset = 1'b0;
        idle(S_HALT, "halt.rst");
        drain();
        n_reset = 1'b1;
        bus.I   = 8'hF0;
        idle(S_RST, "trap1.rst");
        fetch_seq("trap1");
        idle(S_DEC, "trap1.dec");
        repeat (2) idle(S_TRAP, "trap1");
        drain();
        bus.step = 1'b1;
        idle(S_TRAP, "trap1.step");
        drain();
        bus.step = 1'b0;
        idle(S_TRAP, "trap1.hold");
        drain();

        // MOV with dst=00 traps
        n_reset = 1'b0;
        idle(S_TRAP, "trap1.out");
        drain();
        n_reset = 1'b1;
        bus.I   = 8'h44;
        idle(S_RST, "trap2.rst");
        fetch_seq("trap2");
        idle(S_DEC, "trap2.dec");
        repeat (2) idle(S_TRAP, "trap2");
        drain();

        // Jcc (Z=0)
        n_reset = 1'b0;
        idle(S_TRAP, "trap2.out");
        drain();
        n_reset  = 1'b1;
        bus.I    = 8'h61;
        bus.SZCy = 3'b010;
        idle(S_RST, "jcc.rst");
        fetch_seq("jnt");
        idle(S_DEC, "jnt.dec");
`ifdef CDECV_SEQ_JCC_EN
        opnd(S_JMP0, S_JMP1, 1'b1, "jnt");
        drain();
        bus.SZCy = 3'b000;
        fetch_seq("jt");
        idle(S_DEC, "jt.dec");
        opnd(S_JMP0, S_JMP1, 1'b0, "jt");
        waits(S_JMP3, "jt.jmp3");
        push(S_JMP3, 3'd4, 10'h001, OP_Z, 1'b0, 1'b1, "jt.jmp3");
        drain();
`else
        repeat (2) idle(S_TRAP, "jcc.trap");
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cdecv_sequencer.md
Name: cdecv_sequencer

Overview:
- Registered control sequencer for the CDECv CPU. It owns the microstate register and decodes {state, I, SZCy} into datapath controls (xsrc/xdst/aluop/we).
- Supersedes the separate state-register-plus-combinational-decoder pair.
- Adds parametrised memory wait states, ALU and jump instruction classes, monitor run/step control and illegal-opcode trapping.
- Sits between the datapath/bus (I, SZCy, RD timing) and the monitor (run, step, state, halted).

Parameters:
- MEM_WAIT, 0: extra cycles inserted before every RD-consuming microstate (0..7).
- STATE_W, 5: width of the encoded state output.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- n_reset  in  1  reset; synchronous, active-low.
- I  in  8  instruction register contents.
- SZCy  in  3  flags {S,Z,Cy}.
- run  in  1  1 = free-running; 0 = pause at instruction boundary.
- step  in  1  single-cycle pulse; while paused, executes exactly one instruction.
- xsrc  out  3  bus source: PC=0, A=1, B=2, C=3, RD=4, R=5, FLG=6, FF=7.
- xdst  out  10  one-hot load enables, bits [9:0] = FLG, R, T, I, WD, MA, C, B, A, PC; 0 = none.
- aluop  out  4  ALU op: ZERO=0111, INC=1000, ADD=1010, SUB=1011, AND=0100, OR=0101.
- we  out  1  memory write strobe.
- state  out  STATE_W  encoded current microstate, for the monitor.
- instr_done  out  1  one-cycle pulse in the final execute cycle of each instruction.
- paused  out  1  high while in state PAUSE.
- halted  out  1  high in HALT or TRAP.

Behaviour:
- Idle control word: xsrc=FF, xdst=0, aluop=ZERO, we=0.
- n_reset low at an edge: next state is RST. This applies from any state, including mid-instruction and during wait states. The wait counter clears and all outputs are idle.
- RST: transitions to F0 on the next cycle.
- F0:
  - If run=0 and no step is latched: go to PAUSE with an idle control word.
  - Otherwise: PC->MA|R with INC.
- PAUSE: outputs idle, paused=1. Goes to F0 when run=1 or step=1; a step in PAUSE latches one-instruction permission.
- F1: R->PC.
- F2: RD->I. Then go to DEC.
- Wait states: every RD-consuming state (F2, LD3, LD4, ST3, JMP3) is preceded by MEM_WAIT idle wait cycles, counted by a 3-bit counter. With MEM_WAIT=0 there are no wait cycles.
- DEC: one idle cycle that dispatches on I[7:4].
  - 0000 NOP: end.
  - 0001 HALT: go to HALT.
  - 0100 MOV: src I[3:2], dst I[1:0].
  - 0011 ALU.
  - 1000 LD.
  - 1100 ST.
  - 0101 JMP.
  - 0110 Jcc.
  - Anything else: TRAP.
- Register code mapping: 01=A, 10=B, 11=C; code 00 is illegal.
  - MOV with code 00 in src or dst: TRAP.
  - LD with dst=00: TRAP.
  - ST with src=00: TRAP.
  - ALU with dst=00: TRAP.
- MOV: MOV0 performs src->dst. Its end cycle pulses instr_done.
- ALU:
  - ALU0: A->T.
  - ALU1: B onto bus, aluop = I[3:2] {00:ADD, 01:SUB, 10:AND, 11:OR}, loads R|FLG.
  - ALU2: R->dst, end.
- LD:
  - LD0: PC->MA|R, INC.
  - LD1: R->PC.
  - LD3: RD->MA.
  - LD4: RD->dst, end.
- ST:
  - ST0, ST1 and ST3 as in LD (LD0, LD1, LD3); ST3 is RD->MA.
  - ST4: src->WD.
  - ST5: idle with we=1 for exactly one cycle, end.
- JMP:
  - JMP0: PC->MA|R, INC.
  - JMP1: R->PC.
  - JMP3: RD->PC, end.
- HALT: outputs idle, halted=1. Exits only via reset; run and step are ignored.
- TRAP: identical to HALT, and state shows the TRAP encoding.
- End of an instruction: pulse instr_done, then go to F0. A latched step is consumed at this point.
- step while running or mid-instruction: ignored.
- State encodings: fixed, enumerated in the design's state header. All encodings are distinct.

Optional Feature:
- Macro: CDECV_SEQ_JCC_EN.
- Defined: 0110 is Jcc. The condition is I[1:0]: 00 Z=1, 01 Z=0, 10 Cy=1, 11 S=1.
  - Condition true: same sequence as JMP.
  - Condition false: JMP0 (PC->MA|R, INC), JMP1 (R->PC), end. The operand byte is skipped and no RD wait cycles are inserted.
  - SZCy is sampled in DEC.
- Not defined: 0110 goes to TRAP.

Test Plan:
- Reset + MOV: release n_reset, I=0x46 (MOV A,B), run=1, MEM_WAIT=0.
  - Required: RST, F0, F1, F2, DEC, MOV0.
  - MOV0 emits xsrc=1, xdst=0x004; instr_done pulses in MOV0.
- LD with MEM_WAIT=2: I=0x82.
  - Required: exactly 2 idle cycles before each of F2, LD3, LD4.
  - LD4 emits xsrc=4, xdst=0x004.
- ST: I=0xCC (ST C).
  - Required: ST4 emits xsrc=3, xdst=0x020.
  - we=1 in exactly one cycle; no xdst bit set in that cycle.
- Pause/step: run=0.
  - Required: PAUSE with paused=1 indefinitely.
  - One step pulse gives exactly one instruction, one instr_done, then back in PAUSE.
- Illegal opcodes: I=0xF0, or I=0x44 (MOV dst=00).
  - Required: TRAP, halted=1, persists through run and step.
  - n_reset=0 for one cycle leads to RST.
- Jcc (macro on): I=0x61 with SZCy=3'b010.
  - Required: not taken; PC incremented past the operand; no RD->PC.
  - With SZCy=3'b000: taken, JMP3 emits xsrc=4, xdst=0x001.
